// File: rtl/axis_video_pattern_src.sv
// AXI4-Stream RGB565 test-pattern source. It produces whole frames framed with
// TUSER (start of frame) and TLAST (end of line). Pattern and colour are latched only on
// frame boundaries.
module axis_video_pattern_src #(
    parameter int unsigned H_ACTIVE     = 800,
    parameter int unsigned V_ACTIVE     = 600,
    parameter int unsigned FRAME_GAP    = 16,
    parameter int unsigned CHECKER_LOG2 = 5
) (
    input  logic        axi_clk,
    input  logic        axi_rstn,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [15:0] frame_count,
    output logic        busy
);

    localparam int unsigned XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int unsigned BAR_W = H_ACTIVE / 8;
    localparam int unsigned BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int unsigned GW    = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BAR_W - 1);
    localparam logic [GW-1:0] G_LOAD = (FRAME_GAP > 0) ? GW'(FRAME_GAP - 1) : '0;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StGap
    } state_e;

    state_e      r_state, w_state_nxt;
    logic [XW-1:0] r_x, w_x_nxt;
    logic [YW-1:0] r_y, w_y_nxt;
    logic [BW-1:0] r_bcnt, w_bcnt_nxt;    // position inside the current colour bar
    logic [2:0]  r_bar, w_bar_nxt;        // current colour bar, replaces x / BAR_W
    logic [15:0] r_index, w_index_nxt;    // beats since frame start
    logic [GW-1:0] r_gap, w_gap_nxt;
    logic [1:0]  r_sel, w_sel_nxt;
    logic [15:0] r_color, w_color_nxt;
    logic [15:0] r_fc, w_fc_nxt;
    logic [15:0] r_tdata, w_tdata_nxt;
    logic        r_tuser, w_tuser_nxt;
    logic        r_tlast, w_tlast_nxt;
    logic        r_tvalid, w_tvalid_nxt;

    logic        w_xfer;
    logic        w_last_px;
    logic        w_start;
    logic        w_adv;

    logic [XW-1:0] w_adv_x;
    logic [YW-1:0] w_adv_y;
    logic [BW-1:0] w_adv_bcnt;
    logic [2:0]  w_adv_bar;
    logic        w_adv_chk;

    // Pixel colour for a given pattern, bar index, checker parity and beat index.
    function automatic logic [15:0] f_pixel(input logic [1:0]  sel,
                                            input logic [15:0] color,
                                            input logic [2:0]  bar,
                                            input logic        chk,
                                            input logic [15:0] idx);
        logic [15:0] px;
        px = 16'h0000;
        case (sel)
            2'd0: begin
                case (bar)
                    3'd0:    px = 16'hFFFF;
                    3'd1:    px = 16'hFFE0;
                    3'd2:    px = 16'h07FF;
                    3'd3:    px = 16'h07E0;
                    3'd4:    px = 16'hF81F;
                    3'd5:    px = 16'hF800;
                    3'd6:    px = 16'h001F;
                    default: px = 16'h0000;
                endcase
            end
            2'd1:    px = chk ? 16'hFFFF : 16'h0000;
            2'd2:    px = color;
            default: px = idx;
        endcase
        return px;
    endfunction

    assign w_xfer    = r_tvalid && m_axis_tready;
    assign w_last_px = (r_x == X_LAST) && (r_y == Y_LAST);

    // Coordinates and bar position of the pixel following the current one.
    always_comb begin
        w_adv_x    = r_x;
        w_adv_y    = r_y;
        w_adv_bcnt = r_bcnt;
        w_adv_bar  = r_bar;
        if (r_x == X_LAST) begin
            w_adv_x    = '0;
            w_adv_y    = r_y + 1'b1;
            w_adv_bcnt = '0;
            w_adv_bar  = 3'd0;
        end else begin
            w_adv_x = r_x + 1'b1;
            if (r_bcnt == B_LAST) begin
                w_adv_bcnt = '0;
                w_adv_bar  = r_bar + 3'd1;
            end else begin
                w_adv_bcnt = r_bcnt + 1'b1;
            end
        end
        w_adv_chk = 1'(w_adv_x >> CHECKER_LOG2) ^ 1'(w_adv_y >> CHECKER_LOG2);
    end

    // Frame sequencing and next-beat generation.
    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_bcnt_nxt   = r_bcnt;
        w_bar_nxt    = r_bar;
        w_index_nxt  = r_index;
        w_gap_nxt    = r_gap;
        w_sel_nxt    = r_sel;
        w_color_nxt  = r_color;
        w_fc_nxt     = r_fc;
        w_tdata_nxt  = r_tdata;
        w_tuser_nxt  = r_tuser;
        w_tlast_nxt  = r_tlast;
        w_tvalid_nxt = r_tvalid;
        w_start      = 1'b0;
        w_adv        = 1'b0;

        case (r_state)
            StIdle: begin
                if (enable) begin
                    w_start = 1'b1;
                end
            end
            StActive: begin
                if (w_xfer) begin
                    if (w_last_px) begin
                        w_tvalid_nxt = 1'b0;
                        w_tuser_nxt  = 1'b0;
                        w_tlast_nxt  = 1'b0;
                        w_fc_nxt     = r_fc + 16'd1;
                        if (FRAME_GAP > 0) begin
                            w_state_nxt = StGap;
                            w_gap_nxt   = G_LOAD;
                        end else if (enable) begin
                            // No gap: the restart decision is taken on this same edge.
                            w_start = 1'b1;
                        end else begin
                            w_state_nxt = StIdle;
                        end
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
            StGap: begin
                if (r_gap == '0) begin
                    if (enable) begin
                        w_start = 1'b1;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end else begin
                    w_gap_nxt = r_gap - 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase

        if (w_start) begin
            w_state_nxt  = StActive;
            w_x_nxt      = '0;
            w_y_nxt      = '0;
            w_bcnt_nxt   = '0;
            w_bar_nxt    = 3'd0;
            w_index_nxt  = 16'd0;
            w_sel_nxt    = pattern_sel;
            w_color_nxt  = solid_color;
            w_tdata_nxt  = f_pixel(pattern_sel, solid_color, 3'd0, 1'b0, 16'd0);
            w_tuser_nxt  = 1'b1;
            w_tlast_nxt  = 1'b0;
            w_tvalid_nxt = 1'b1;
        end else if (w_adv) begin
            w_x_nxt      = w_adv_x;
            w_y_nxt      = w_adv_y;
            w_bcnt_nxt   = w_adv_bcnt;
            w_bar_nxt    = w_adv_bar;
            w_index_nxt  = r_index + 16'd1;
            w_tdata_nxt  = f_pixel(r_sel, r_color, w_adv_bar, w_adv_chk, r_index + 16'd1);
            w_tuser_nxt  = 1'b0;
            w_tlast_nxt  = (w_adv_x == X_LAST);
            w_tvalid_nxt = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            r_state  <= StIdle;
            r_x      <= '0;
            r_y      <= '0;
            r_bcnt   <= '0;
            r_bar    <= 3'd0;
            r_index  <= 16'd0;
            r_gap    <= '0;
            r_sel    <= 2'd0;
            r_color  <= 16'd0;
            r_fc     <= 16'd0;
            r_tdata  <= 16'd0;
            r_tuser  <= 1'b0;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_bcnt   <= w_bcnt_nxt;
            r_bar    <= w_bar_nxt;
            r_index  <= w_index_nxt;
            r_gap    <= w_gap_nxt;
            r_sel    <= w_sel_nxt;
            r_color  <= w_color_nxt;
            r_fc     <= w_fc_nxt;
            r_tdata  <= w_tdata_nxt;
            r_tuser  <= w_tuser_nxt;
            r_tlast  <= w_tlast_nxt;
            r_tvalid <= w_tvalid_nxt;
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tuser  = r_tuser;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tvalid = r_tvalid;
    assign frame_count   = r_fc;
    assign busy          = (r_state != StIdle);

endmodule

// File: tb/tb_axis_video_pattern_src.sv
// Self-checking bench for axis_video_pattern_src. It uses a small 16x4 frame and compares
// every beat against a reference computed from the pattern rules.
module tb_axis_video_pattern_src;

    localparam int H  = 16;
    localparam int V  = 4;
    localparam int NB = H * V;
    localparam int C  = 1;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en_a = 1'b0;
    logic        en_b = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [15:0] solid_color = 16'd0;
    logic        tready = 1'b0;

    logic [15:0] data_a, data_b, fc_a, fc_b;
    logic        user_a, user_b, last_a, last_b, vld_a, vld_b, busy_a, busy_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axis_video_pattern_src #(
        .H_ACTIVE(H), .V_ACTIVE(V), .FRAME_GAP(2), .CHECKER_LOG2(C)
    ) dut_a (
        .axi_clk(clk), .axi_rstn(rstn), .enable(en_a), .pattern_sel(pattern_sel),
        .solid_color(solid_color), .m_axis_tdata(data_a), .m_axis_tuser(user_a),
        .m_axis_tlast(last_a), .m_axis_tvalid(vld_a), .m_axis_tready(tready),
        .frame_count(fc_a), .busy(busy_a)
    );

    axis_video_pattern_src #(
        .H_ACTIVE(H), .V_ACTIVE(V), .FRAME_GAP(0), .CHECKER_LOG2(C)
    ) dut_b (
        .axi_clk(clk), .axi_rstn(rstn), .enable(en_b), .pattern_sel(pattern_sel),
        .solid_color(solid_color), .m_axis_tdata(data_b), .m_axis_tuser(user_b),
        .m_axis_tlast(last_b), .m_axis_tvalid(vld_b), .m_axis_tready(tready),
        .frame_count(fc_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference pixel for beat k of a frame.
    function automatic logic [15:0] exp_pix(input int sel, input logic [15:0] col, input int k);
        int x;
        int y;
        x = k % H;
        y = k / H;
        case (sel)
            0: begin
                case (x / (H / 8))
                    0:       return 16'hFFFF;
                    1:       return 16'hFFE0;
                    2:       return 16'h07FF;
                    3:       return 16'h07E0;
                    4:       return 16'hF81F;
                    5:       return 16'hF800;
                    6:       return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
            1:       return ((((x >> C) ^ (y >> C)) & 1) != 0) ? 16'hFFFF : 16'h0000;
            2:       return col;
            default: return 16'(k);
        endcase
    endfunction

    // Receives one frame from DUT a (which=0) or b (which=1), checking every presented beat.
    // lead counts idle cycles before the first beat. At beat drop_at the enable is dropped.
    // At beat chg_at pattern_sel/solid_color change to nsel/ncol.
    task automatic recv_frame(input bit which, input int sel, input logic [15:0] col,
                              input int rdy_pct, input int drop_at, input int chg_at,
                              input logic [1:0] nsel, input logic [15:0] ncol,
                              output int lead);
        int k;
        int cyc;
        bit dropped;
        bit chg;
        logic v;
        logic [15:0] d;
        logic u;
        logic l;
        k = 0;
        cyc = 0;
        lead = 0;
        dropped = 1'b0;
        chg = 1'b0;
        while (k < NB && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (!dropped && k == drop_at) begin
                if (which) en_b = 1'b0;
                else en_a = 1'b0;
                dropped = 1'b1;
            end
            if (!chg && k == chg_at) begin
                pattern_sel = nsel;
                solid_color = ncol;
                chg = 1'b1;
            end
            v = which ? vld_b : vld_a;
            d = which ? data_b : data_a;
            u = which ? user_b : user_a;
            l = which ? last_b : last_a;
            tready = ($urandom_range(99) < rdy_pct);
            if (v) begin
                check("tdata", d, exp_pix(sel, col, k));
                check("tuser", u, (k == 0));
                check("tlast", l, ((k % H) == H - 1));
                if (tready) k++;
            end else if (k == 0) begin
                lead++;
            end else begin
                check("tvalid_in_frame", v, 1);
            end
        end
        if (k < NB) check("frame_len_timeout", k, NB);
    endtask

    initial begin
        int lead;
        int cnt;
        int cur_sel;
        int cyc;
        logic [15:0] cur_col;
        logic [1:0]  nsel;
        logic [15:0] ncol;
        int drop;

        repeat (3) @(negedge clk);
        check("rst_tvalid_during", vld_a, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_tvalid", vld_a, 0);
        check("rst_tuser", user_a, 0);
        check("rst_tlast", last_a, 0);
        check("rst_tdata", data_a, 0);
        check("rst_fc", fc_a, 0);
        check("rst_busy", busy_a, 0);

        // Colour bars, enable pulsed for one cycle, sink always ready.
        pattern_sel = 2'd0;
        en_a = 1'b1;
        recv_frame(0, 0, 16'h0, 100, 0, -1, 2'd0, 16'h0, lead);
        check("bars_lead", lead, 0);
        @(negedge clk);
        check("bars_fc", fc_a, 1);
        repeat (4) @(negedge clk);
        check("bars_busy_idle", busy_a, 0);
        check("bars_tvalid_idle", vld_a, 0);

        // Index pattern with a 50% ready sink.
        pattern_sel = 2'd3;
        en_a = 1'b1;
        recv_frame(0, 3, 16'h0, 50, 0, -1, 2'd3, 16'h0, lead);
        check("index_lead", lead, 0);
        @(negedge clk);
        check("index_fc", fc_a, 2);
        repeat (4) @(negedge clk);

        // Solid colour changed mid-frame; enable then dropped at beat 10 of frame 2.
        pattern_sel = 2'd2;
        solid_color = 16'h1234;
        en_a = 1'b1;
        recv_frame(0, 2, 16'h1234, 100, -1, 20, 2'd2, 16'hABCD, lead);
        check("solid1_lead", lead, 0);
        recv_frame(0, 2, 16'hABCD, 100, 10, -1, 2'd2, 16'hABCD, lead);
        check("solid2_gap", lead, 2);
        @(negedge clk);
        check("solid_fc", fc_a, 4);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (vld_a) cnt++;
        end
        check("after_drop_beats", cnt, 0);
        check("after_drop_busy", busy_a, 0);

        // Random patterns with random mid-frame selection changes; the change applies next frame.
        cur_sel = $urandom_range(3);
        cur_col = 16'($urandom);
        pattern_sel = 2'(cur_sel);
        solid_color = cur_col;
        en_a = 1'b1;
        for (int f = 0; f < 4; f++) begin
            nsel = 2'($urandom_range(3));
            ncol = 16'($urandom);
            drop = (f == 3) ? int'($urandom_range(1, 60)) : -1;
            recv_frame(0, cur_sel, cur_col, 70, drop, int'($urandom_range(1, 62)), nsel, ncol,
                       lead);
            check("rand_lead", lead, (f == 0) ? 0 : 2);
            cur_sel = int'(nsel);
            cur_col = ncol;
        end
        @(negedge clk);
        check("rand_fc", fc_a, 8);
        repeat (5) @(negedge clk);

        // Reset asserted in the middle of an index frame.
        pattern_sel = 2'd3;
        tready = 1'b1;
        en_a = 1'b1;
        cnt = 0;
        cyc = 0;
        while (cnt < 30 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (vld_a) cnt++;
        end
        check("pre_reset_beats", cnt, 30);
        en_a = 1'b0;
        rstn = 1'b0;
        #1;
        check("async_rst_tvalid", vld_a, 0);
        check("async_rst_fc", fc_a, 0);
        check("async_rst_tuser", user_a, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_idle_valid", vld_a, 0);
        check("post_rst_idle_busy", busy_a, 0);
        en_a = 1'b1;
        recv_frame(0, 3, 16'h0, 100, 0, -1, 2'd3, 16'h0, lead);
        check("post_rst_lead", lead, 0);
        @(negedge clk);
        check("post_rst_fc", fc_a, 1);
        repeat (4) @(negedge clk);

        // Zero frame gap: frame N+1 follows frame N with no idle cycle.
        pattern_sel = 2'd3;
        en_b = 1'b1;
        recv_frame(1, 3, 16'h0, 100, -1, -1, 2'd3, 16'h0, lead);
        check("gap0_lead1", lead, 0);
        recv_frame(1, 3, 16'h0, 80, 5, -1, 2'd3, 16'h0, lead);
        check("gap0_lead2", lead, 0);
        @(negedge clk);
        check("gap0_fc", fc_b, 2);
        @(negedge clk);
        check("gap0_idle_valid", vld_b, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_video_pattern_src.md
Name: axis_video_pattern_src

Overview:
- AXI4-Stream video source that produces whole RGB565 frames for the VGA controller's s_axis slave port, running in the axi_clk domain.
- Marks the first pixel of each frame with TUSER[0] and the last pixel of each line with TLAST, which is the framing the VGA controller expects.
- Provides color bars, a checkerboard, a solid color and an incrementing-index pattern for bring-up and CDC/FIFO verification without a framebuffer.
- Frames start only on frame boundaries; pattern changes take effect only on frame boundaries.

Parameters:
- H_ACTIVE, 800, pixels per line (≥8, multiple of 8).
- V_ACTIVE, 600, lines per frame (≥1).
- FRAME_GAP, 16, idle cycles with tvalid=0 between frames (0 allowed).
- CHECKER_LOG2, 5, checker square size is 2^CHECKER_LOG2 pixels.

Ports:
- axi_clk, in, 1: single clock.
- axi_rstn, in, 1: reset, asynchronous, active-low.
- enable, in, 1: stream frames while high; a frame in progress is finished after enable drops.
- pattern_sel, in, 2: 0 = bars, 1 = checker, 2 = solid, 3 = index. Sampled at frame start.
- solid_color, in, 16: RGB565 color for pattern 2. Sampled at frame start.
- m_axis_tdata, out, 16: RGB565 pixel.
- m_axis_tuser, out, 1: start of frame, high on pixel (0,0) only.
- m_axis_tlast, out, 1: end of line, high when x = H_ACTIVE-1.
- m_axis_tvalid, out, 1: beat valid.
- m_axis_tready, in, 1: sink ready.
- frame_count, out, 16: number of completed frames, wraps modulo 2^16.
- busy, out, 1: high in states ACTIVE and GAP.

Behaviour:
- Reset (async assert, sync release): state = IDLE; x = y = 0; frame_count = 0; tvalid = tuser = tlast = 0; tdata = 0; busy = 0; latched sel/color = 0.
- All m_axis outputs are registered; no combinational path from tready to any output.
- State IDLE:
  - If enable = 1 at a clock edge: latch pattern_sel and solid_color, set x = y = 0, go to ACTIVE.
  - At that same edge, present pixel (0,0) with tvalid = 1 and tuser = 1. First beat is therefore visible 1 cycle after enable is sampled high.
- State ACTIVE:
  - A beat transfers when tvalid && tready.
  - While tvalid && !tready, tdata, tuser and tlast hold stable.
  - On transfer: advance x; at x = H_ACTIVE-1, wrap x to 0 and increment y. The next beat is presented on the same edge, so back-to-back beats at 1/clock are possible.
  - On transfer of the last pixel (H_ACTIVE-1, V_ACTIVE-1): tvalid <= 0; frame_count increments.
    - If FRAME_GAP > 0: go to GAP with gap counter loaded to FRAME_GAP-1.
    - If FRAME_GAP = 0: treat as the GAP-expiry decision at that same edge.
- State GAP:
  - tvalid = 0; the gap counter decrements each cycle.
  - When the counter reaches 0:
    - enable = 1: latch sel/color, present (0,0) with tuser = 1, go to ACTIVE.
    - enable = 0: go to IDLE.
- enable is ignored inside ACTIVE. Frames are never truncated by enable.
- Pattern generation (pure function of x, y and the latched sel/color, computed for the next beat):
  - Pattern 0, bars: bar = x / (H_ACTIVE/8). Bars 0..7 are FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. Use a bar-boundary counter, not a divider.
  - Pattern 1, checker: (x[CHECKER_LOG2] ^ y[CHECKER_LOG2]) ? FFFF : 0000.
  - Pattern 2, solid: the latched solid_color.
  - Pattern 3, index: 16-bit count of beats since frame start. It starts at 0 at pixel (0,0) and wraps modulo 2^16.
- Counter widths are $clog2 of H_ACTIVE and V_ACTIVE. Compare with explicit widths; no truncation warnings.
- Reset asserted mid-frame: outputs clear immediately. After release, the source stays in IDLE until enable, and the next frame begins with tuser = 1 at (0,0).
- Simultaneous events:
  - Last beat transfers and pattern_sel changes in the same cycle: the new value is used only if it is still present at the next latch point.
  - frame_count wraps from FFFF to 0000 without any side effect.

Test Plan:
- H_ACTIVE=16, V_ACTIVE=4, FRAME_GAP=2, sel=0, tready=1, enable pulsed 1 cycle:
  - exactly 64 beats, tuser only on beat 0, tlast on beats 15/31/47/63.
  - bar colors change every 2 beats: FFFF, FFFF, FFE0, …, 0000.
  - frame_count = 1, then IDLE with busy = 0.
- Same config, sel=3, random tready (50%):
  - tdata sequence is 0..63 with no gaps or duplicates.
  - outputs stay stable across every stall cycle; frame length is unchanged.
- enable held high, sel=2, solid_color=0x1234, change solid_color to 0xABCD mid-frame:
  - frame 1 is all 0x1234; frame 2 is all 0xABCD.
  - exactly 2 tvalid = 0 cycles between the last beat of frame 1 and the tuser beat of frame 2.
- enable dropped at beat 10 of a frame: the frame completes all 64 beats, then the source idles and frame_count increments by exactly 1.
- axi_rstn asserted at beat 30 for 3 cycles:
  - tvalid = 0 asynchronously and frame_count = 0.
  - after re-enable, the first beat is tuser = 1, tdata index 0.
- FRAME_GAP=0, enable high: the tuser beat of frame N+1 directly follows the final tlast beat of frame N, with no idle cycle.
